// File: rtl/lagd_run_ctrl_if.sv
// Macro-side config/runtime control bundle of the run sequencer.
// The sequencer takes the master modport; the macro (or a bench) takes slave.
interface lagd_run_ctrl_if;
    logic cfg_em_valid_o;
    logic cfg_em_ready_i;
    logic cfg_fm_valid_o;
    logic cfg_fm_ready_i;
    logic cfg_aw_valid_o;
    logic dt_cfg_enable_o;
    logic dt_cfg_idle_i;
    logic cmpt_en_o;
    logic cmpt_idle_i;
    logic energy_valid_i;
    logic energy_ready_i;
    logic flush_o;

    modport master (
        output cfg_em_valid_o, cfg_fm_valid_o, cfg_aw_valid_o,
               dt_cfg_enable_o, cmpt_en_o, flush_o,
        input  cfg_em_ready_i, cfg_fm_ready_i, dt_cfg_idle_i,
               cmpt_idle_i, energy_valid_i, energy_ready_i
    );

    modport slave (
        input  cfg_em_valid_o, cfg_fm_valid_o, cfg_aw_valid_o,
               dt_cfg_enable_o, cmpt_en_o, flush_o,
        output cfg_em_ready_i, cfg_fm_ready_i, dt_cfg_idle_i,
               cmpt_idle_i, energy_valid_i, energy_ready_i
    );
endinterface

// File: rtl/lagd_run_ctrl.sv
// Run-level sequencer: configures the macro, optionally loads data, runs a
// bounded or host-stopped compute phase, then drains and flushes.
module lagd_run_ctrl #(
    parameter int ITER_W         = 16,
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 2**20-1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              skip_load_i,
    input  logic [ITER_W-1:0] iter_limit_i,
    lagd_run_ctrl_if.master   macro,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ITER_W-1:0] iter_count_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_EM, S_CFG_FM, S_CFG_AW, S_LOAD,
        S_LOAD_WAIT, S_RUN, S_DRAIN, S_FLUSH, S_DONE
    } state_e;

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic [ITER_W-1:0]   limit_q, limit_d;
    logic                skip_q, skip_d;
    logic                err_q, err_d;
    logic                seen_busy_q, seen_busy_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    logic wdog_state, timeout, energy_hs;
    logic em_valid, fm_valid, aw_valid, dt_enable, cmpt_en, flush, done;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + ITER_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        limit_d     = limit_q;
        skip_d      = skip_q;
        err_d       = err_q;
        seen_busy_d = seen_busy_q;
        wdog_d      = '0;
        em_valid    = 1'b0;
        fm_valid    = 1'b0;
        aw_valid    = 1'b0;
        dt_enable   = 1'b0;
        cmpt_en     = 1'b0;
        flush       = 1'b0;
        done        = 1'b0;
        energy_hs   = macro.energy_valid_i & macro.energy_ready_i;
        wdog_state  = (state_q == S_CFG_EM) || (state_q == S_CFG_FM) ||
                      (state_q == S_LOAD_WAIT) || (state_q == S_DRAIN);
        timeout     = wdog_state && (wdog_q == WDOG_LAST);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    limit_d = iter_limit_i;
                    skip_d  = skip_load_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_CFG_EM;
                end
            end
            S_CFG_EM: begin
                em_valid = 1'b1;
                if (macro.cfg_em_ready_i) state_d = S_CFG_FM;
            end
            S_CFG_FM: begin
                fm_valid = 1'b1;
                if (macro.cfg_fm_ready_i) state_d = S_CFG_AW;
            end
            S_CFG_AW: begin
                aw_valid = 1'b1;
                state_d  = skip_q ? S_RUN : S_LOAD;
            end
            S_LOAD: begin
                dt_enable   = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                // Idle is only trusted after the engine has been seen busy.
                if (!macro.dt_cfg_idle_i) seen_busy_d = 1'b1;
                else if (seen_busy_q)     state_d     = S_RUN;
            end
            S_RUN: begin
                cmpt_en = 1'b1;
                if (energy_hs) cnt_d = sat_inc(cnt_q);
                if (((limit_q != '0) && (cnt_d == limit_q)) || stop_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (macro.cmpt_idle_i) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush   = 1'b1;
                state_d = err_q ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Progress on the final watchdog cycle still wins over the timeout.
        if (wdog_state && (state_d == state_q)) begin
            if (timeout) begin
                err_d   = 1'b1;
                state_d = S_FLUSH;
            end else begin
                wdog_d = wdog_q + TIMEOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            seen_busy_q <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            seen_busy_q <= seen_busy_d;
            wdog_q      <= wdog_d;
        end
    end

    always_ff @(posedge clk_i) begin
        limit_q <= limit_d;
        skip_q  <= skip_d;
    end

    assign macro.cfg_em_valid_o  = em_valid;
    assign macro.cfg_fm_valid_o  = fm_valid;
    assign macro.cfg_aw_valid_o  = aw_valid;
    assign macro.dt_cfg_enable_o = dt_enable;
    assign macro.cmpt_en_o       = cmpt_en;
    assign macro.flush_o         = flush;
    assign busy_o                = (state_q != S_IDLE);
    assign done_o                = done;
    assign err_o                 = err_q;
    assign iter_count_o          = cnt_q;

endmodule

// File: doc/lagd_run_ctrl.md
Name: lagd_run_ctrl

Overview:
- Run-level sequencer for the digital compute macro. Executes one annealing run per start request: configures the energy monitor, flip manager and analog wrap in order; optionally triggers J/h/SFC data loading; enables computation for a programmed number of energy iterations; then drains and flushes.
- Sits between the host register file and the macro's config/runtime control inputs. Reports busy, done, error and the iteration count back to the host.

Parameters:
- ITER_W, 16, width of the iteration limit and iteration counter.
- TIMEOUT_W, 20, width of the watchdog counter.
- TIMEOUT_CYCLES, 2**20-1, maximum cycles any wait state may stall before an error is raised.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  start a run; sampled only in IDLE.
- stop_i  in  1  host abort request; honoured only in RUN.
- skip_load_i  in  1  sampled with start_i; 1 = skip the data-load phase.
- iter_limit_i  in  ITER_W  number of energy handshakes per run; 0 = unbounded, run until stop_i; sampled with start_i.
- cfg_em_valid_o  out  1  energy monitor config valid.
- cfg_em_ready_i  in  1  energy monitor config ready.
- cfg_fm_valid_o  out  1  flip manager spin-config valid.
- cfg_fm_ready_i  in  1  flip manager spin-config ready.
- cfg_aw_valid_o  out  1  analog wrap config enable (pulse).
- dt_cfg_enable_o  out  1  data-load trigger (pulse).
- dt_cfg_idle_i  in  1  data-load engine idle.
- cmpt_en_o  out  1  compute enable to flip manager.
- cmpt_idle_i  in  1  flip manager compute idle.
- energy_valid_i  in  1  energy monitor to flip manager valid (observed).
- energy_ready_i  in  1  matching ready (observed).
- flush_o  out  1  flush pulse to flip manager.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a run completes.
- err_o  out  1  sticky watchdog error.
- iter_count_o  out  ITER_W  energy handshakes counted in the current/last run.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE.
  - All outputs 0.
  - iter_count_o=0, err_o=0.
  - Reset mid-run aborts immediately; no flush pulse is generated.
- States: IDLE, CFG_EM, CFG_FM, CFG_AW, LOAD, LOAD_WAIT, RUN, DRAIN, FLUSH, DONE.
- IDLE, start_i=1:
  - Latch iter_limit_i and skip_load_i.
  - Clear iter_count_o and err_o.
  - Go to CFG_EM next cycle.
- CFG_EM: cfg_em_valid_o=1 until the cycle with cfg_em_ready_i=1, then go to CFG_FM. Valid drops the cycle after the handshake.
- CFG_FM: same rule with cfg_fm_valid_o and cfg_fm_ready_i, then go to CFG_AW.
- CFG_AW: cfg_aw_valid_o=1 for exactly one cycle. Next state is LOAD, or RUN if skip_load was latched 1.
- LOAD: dt_cfg_enable_o=1 for exactly one cycle, then go to LOAD_WAIT.
- LOAD_WAIT:
  - First wait for dt_cfg_idle_i=0 (engine started), then for dt_cfg_idle_i=1.
  - Then go to RUN. Stale idle=1 from before the trigger is ignored.
- RUN:
  - cmpt_en_o=1.
  - iter_count_o increments by 1 on each cycle with energy_valid_i & energy_ready_i. It saturates at all-ones.
  - Exit to DRAIN when the limit is nonzero and the post-increment count equals it, or when stop_i=1.
  - cmpt_en_o is 0 from the DRAIN entry cycle onward.
  - Limit and stop coinciding on the same cycle: count the handshake, then exit once.
- DRAIN: wait for cmpt_idle_i=1, then go to FLUSH.
- FLUSH: flush_o=1 for one cycle, then go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
  - iter_count_o holds its value until the next start.
  - start_i is ignored outside IDLE.
- Watchdog:
  - Counts cycles spent in CFG_EM, CFG_FM, LOAD_WAIT and DRAIN. It resets to 0 on every state change.
  - On reaching TIMEOUT_CYCLES: set err_o=1, drop all valids/enables, go to FLUSH, then IDLE. No done_o pulse is generated on this path.
  - err_o is cleared only by rst_i or the next accepted start.
  - RUN is not watchdogged.
- Latency: start to cfg_em_valid_o = 1 cycle. With immediate readies and skip_load=1, start to cmpt_en_o = 4 cycles.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, busy_o=0.
- start, skip_load=1, iter_limit=3, readies tied 1, 3 energy handshakes, cmpt_idle=1 -> sequence is cfg_em, cfg_fm, cfg_aw each for 1 cycle, then cmpt_en high, flush_o pulse, done_o pulse; iter_count_o=3 at done.
- cfg_em_ready_i held 0 for 5 cycles -> cfg_em_valid_o high for 6 cycles, with no advance until ready.
- skip_load=0, dt_cfg_idle_i stays 1 for 4 cycles after the pulse, then 0 for 10 cycles, then 1 -> dt_cfg_enable_o pulses once; RUN entered only after the 0→1 transition.
- iter_limit=0, 7 handshakes, then stop_i asserted together with an 8th handshake -> iter_count_o=8, cmpt_en_o drops the next cycle, single done_o.
- TIMEOUT_CYCLES=16 with cmpt_idle_i stuck 0 in DRAIN -> err_o=1 after 16 cycles, flush_o pulses, no done_o, back in IDLE. Next start clears err_o.
- rst_i asserted in RUN -> IDLE next edge, cmpt_en_o=0, flush_o stays 0.
